// File: rtl/fetch_queue_pkg.sv
// Shared widths and encodings for the IF/ID fetch queue.
package fetch_queue_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int INST_W_DEF = 32;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam int KILL_W = 2;

   // Out-of-range kill settings saturate at the widest count the timer holds.
   function automatic logic [KILL_W-1:0] kill_load(input int k);
      if (k < 0)
         return '0;
      else if (k > (1 << KILL_W) - 1)
         return '1;
      else
         return KILL_W'(k);
   endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port.
module fetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   // Not reset: the owner qualifies every read with its own entry count.
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i)
         mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry IF/ID instruction buffer with valid/ready on both sides, branch
// flush, and a post-flush kill window for stale in-flight fetch beats.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int ADDR_W           = ADDR_W_DEF,
   parameter int INST_W           = INST_W_DEF,
   parameter int DEPTH            = 4,
   parameter int KILL_AFTER_FLUSH = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       if_valid_i,
   input  logic [ADDR_W-1:0]          if_pc_i,
   input  logic [INST_W-1:0]          if_inst_i,
   output logic                       if_ready_o,
   output logic                       id_valid_o,
   output logic [ADDR_W-1:0]          id_pc_o,
   output logic [INST_W-1:0]          id_inst_o,
   input  logic                       id_ready_i,
   input  logic                       id_b_flag_i,
   input  logic                       ex_b_flag_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int ENTRY_W = ADDR_W + INST_W;

   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [KILL_W-1:0] KILL_LOAD = kill_load(KILL_AFTER_FLUSH);

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [KILL_W-1:0]  kill_cnt_q, kill_cnt_d;

   logic               flush;
   logic               accept;
   logic               push;
   logic               kill;
   logic               pop;
   logic [ENTRY_W-1:0] rd_entry;

   always_comb begin
      flush      = id_b_flag_i | ex_b_flag_i;
      if_ready_o = (count_q < FULL_CNT);
      id_valid_o = (count_q != '0);
      // A flush swallows the IF beat of its own cycle outright.
      accept     = if_valid_i & if_ready_o & ~flush;
      push       = accept & (kill_cnt_q == '0);
      kill       = accept & (kill_cnt_q != '0);
      pop        = id_valid_o & id_ready_i & ~flush;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      kill_cnt_d = kill_cnt_q;

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         kill_cnt_d = KILL_LOAD;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
         if (kill)
            kill_cnt_d = kill_cnt_q - 1'b1;

         if (push && !pop)
            count_d = count_q + 1'b1;
         else if (pop && !push)
            count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         kill_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         kill_cnt_q <= kill_cnt_d;
      end
   end

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i ({if_pc_i, if_inst_i}),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   // Empty queue presents a bubble rather than stale storage.
   always_comb begin
      id_pc_o   = '0;
      id_inst_o = '0;
      if (id_valid_o) begin
         id_pc_o   = rd_entry[ENTRY_W-1:INST_W];
         id_inst_o = rd_entry[INST_W-1:0];
      end
   end

   assign count_o = count_q;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction buffer between fetch (IF) and decode (ID). It replaces the single-entry IF/ID register with a DEPTH-entry FIFO that uses valid/ready handshakes on both sides. It flushes all buffered entries on a branch redirect from ID or EX. After a flush it can discard a programmable number of stale fetch beats that were already in flight.

## Interface
Parameters:
- ADDR_W, 32: PC width
- INST_W, 32: instruction width
- DEPTH, 4: entry count; power of two, ≥2
- KILL_AFTER_FLUSH, 1: number of accepted IF beats discarded after a flush (0..3)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; asynchronous, active-low; clears all state immediately
- if_valid_i  in  1  IF presents a fetched instruction
- if_pc_i  in  ADDR_W  PC of that instruction
- if_inst_i  in  INST_W  instruction word
- if_ready_o  out  1  queue can accept a beat this cycle
- id_valid_o  out  1  head entry is valid
- id_pc_o  out  ADDR_W  head PC; all-zero when id_valid_o=0
- id_inst_o  out  INST_W  head instruction; all-zero (bubble) when id_valid_o=0
- id_ready_i  in  1  ID consumes the head this cycle; low means ID is stalled
- id_b_flag_i  in  1  branch/jump redirect resolved in ID
- ex_b_flag_i  in  1  branch/jump redirect resolved in EX
- count_o  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- flush = id_b_flag_i | ex_b_flag_i.
- Push condition: if_valid_i & if_ready_o & ~flush & (kill_cnt==0). The pushed beat is written at wr_ptr and wr_ptr increments.
- Kill condition: if_valid_i & if_ready_o & ~flush & (kill_cnt!=0). The beat is accepted and dropped, and kill_cnt decrements.
- Pop condition: id_valid_o & id_ready_i & ~flush. rd_ptr increments.
- if_ready_o = (count < DEPTH). When full, the queue does not accept a beat even in a cycle that also pops.
- id_valid_o = (count != 0). The head is driven combinationally from storage[rd_ptr]. The outputs are forced to zero when the queue is empty.
- Flush has priority over push, pop and kill in the same cycle:
  - count, rd_ptr and wr_ptr are cleared to 0.
  - The IF beat in that cycle is discarded.
  - kill_cnt is loaded with KILL_AFTER_FLUSH.
- Flush asserted during a stall (id_ready_i=0) takes effect the same edge. No pending-flush state is needed.
- A flush while kill_cnt≠0 reloads kill_cnt.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count updates by +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
- A kill never changes count.

## Timing
- Reset values: count_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, if_ready_o=1, kill_cnt=0, pointers=0.
- Latency from IF to ID is 1 cycle: a beat pushed at edge N is visible at the head after edge N if the queue was empty.
- ID-side stall (id_ready_i=0) holds the head stable for any number of cycles.
- Throughput is 1 beat/cycle whenever count < DEPTH.
- A flush at edge N causes id_valid_o=0 and count_o=0 from N onward.
- Reset asserted mid-operation clears all state asynchronously. Outputs reach their reset values without waiting for a clock edge.
- Deassertion of rst is synchronised externally.

## Structure
- Shared defines header (existing style) holds ZeroWord, the address/instruction widths and the Stop/NoStop encodings. Parameter defaults come from these.
- One sub-module is natural: fetch_queue_mem, a DEPTH×(ADDR_W+INST_W) register array with one write port and one asynchronous read port. Its storage is not reset; validity comes only from count.
- Pointer, count and kill-counter logic live in fetch_queue.

## Test plan
- Fill/drain: hold id_ready_i=0 and push PCs 0x0,0x4,0x8,0xC → count_o=4, if_ready_o=0. Then set id_ready_i=1 → heads appear in order 0x0..0xC and count_o returns to 0.
- Simultaneous push/pop with count=2 → count_o stays 2 and order is preserved across pointer wrap (≥3 DEPTH cycles).
- Flush with count=3 and id_ready_i=0 → next cycle id_valid_o=0, id_pc_o=0, id_inst_o=0. The IF beat in the flush cycle is not stored.
- Kill window with KILL_AFTER_FLUSH=1: flush, then push 0x100 and 0x104 → 0x100 is dropped and 0x104 is the first head. A second flush during the kill window reloads the kill count, so the next beat is again dropped.
- Async reset asserted mid-burst with count=3 → count_o=0 and id_valid_o=0 immediately, before the next clock edge.
- Simultaneous id_b_flag_i and ex_b_flag_i with a push and a pop → same result as a single flush; count_o=0.
